wam_game_sequencer: RTL and testbench
=====================================

Name: wam_game_sequencer

Overview:
- Central game controller for the whack-a-mole board. Sits between the switch settings, the random-number source, the keypad controller and the light controller.
- Latches difficulty, game mode and point target at game start. Then runs a between-delay, light-on, hit-check loop that picks one of nine lights per round.
- Scores hits and misses, and declares game over and win/lose according to the selected mode.

Parameters:
- T_UNIT, 12_500_000: clock cycles per 0.25 s time unit. Benches override it with a small value.
- TIMED_UNITS, 240: game length in timed mode, in units (60 s).
- LEVEL_STEP, 5: hits needed per level advance in continuity mode.
- NORMAL_PTS, 25: rounds per game when ext_points=0.
- EXT_PTS, 50: rounds per game when ext_points=1.

Ports:
- CLOCK_50  in  1  system clock
- resetn  in  1  asynchronous active-low reset (board KEY[0])
- start  in  1  one-cycle pulse; starts a game
- difficulty  in  4  one-hot level select, same coding as SW[3:0]
- gamemode  in  4  one-hot mode select: [0] normal, [1] timed, [2] deathmatch, [3] continuity
- ext_points  in  1  0 selects NORMAL_PTS, 1 selects EXT_PTS
- rand_num  in  16  free-running random value
- key_valid  in  1  one-cycle keypad press strobe
- key_code  in  4  pressed key index, 0..8 valid
- light_en  out  1  a light is lit
- light_idx  out  4  index of the lit light, 0..8
- hit_count  out  6  hits, saturating at 63
- miss_count  out  6  misses, saturating at 63
- round_count  out  6  rounds played, saturating at 63
- level  out  3  current level, 1..4
- busy  out  1  game in progress
- game_over  out  1  game finished
- win  out  1  result, valid while game_over=1

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0 except level=1.
- Level timing, in units of T_UNIT, as between-delay / on-time:
  - L1: 8 / 8
  - L2: 4 / 4
  - L3: 2 / 4
  - L4: 1 / 2
  - Counters load k*T_UNIT-1 and count down to 0. Width is 28 bits.
- Difficulty decode: 4'b0001→L1, 0010→L2, 0100→L3, 1000→L4. Any other value→L2. Gamemode non-one-hot→normal.
- IDLE: on start, latch mode, level and target. Clear all counts, game_over and win. Set busy=1. Go to WAIT.
- WAIT: light_en=0; key presses are ignored. When the between counter hits 0, go to ON on the next cycle:
  - light_idx = rand_num[3:0] if it is <9, else rand_num[3:0]-9.
  - light_en=1 in the same cycle ON is entered.
  - The on-counter is loaded.
- ON:
  - key_valid with key_code==light_idx → hit.
  - key_valid with any other code → miss.
  - On-counter reaching 0 with no press → miss.
  - If key_valid coincides with timeout, the key wins.
  - Leave ON to SCORE; light_en drops on SCORE entry.
- SCORE (1 cycle): increment round_count and hit_count or miss_count (saturating). Then evaluate end conditions:
  - normal / continuity: round_count reaches target → DONE; win = hit_count ≥ miss_count.
  - deathmatch: a miss → DONE with win=0. Reaching target with no miss → DONE with win=1.
  - timed: target ignored.
  - If no end condition applies, go to WAIT.
- Continuity: level starts at 1 regardless of difficulty. It increments after every LEVEL_STEP hits, capped at 4. The new timing applies from the next WAIT.
- Timed:
  - A separate game timer runs TIMED_UNITS units from start.
  - On expiry, go to DONE at the next cycle from any state. A lit light is abandoned and not scored.
  - win = hit_count ≥ NORMAL_PTS.
- DONE: busy=0, game_over=1, win held. A start pulse behaves as in IDLE (new game).
- start while busy: ignored.
- Latched settings ignore switch changes mid-game.
- resetn low mid-game: immediate return to IDLE with outputs cleared.

Decomposition:
- Package wam_pkg holds:
  - the state encoding (IDLE, WAIT, ON, SCORE, DONE);
  - mode/level one-hot constants;
  - the level→(between,on) unit multipliers;
  - counter widths.
- Sub-module wam_countdown (loadable 28-bit down-counter with load, enable and zero flag), instantiated for the between/on timer and the game timer.

Test Plan:
- T_UNIT=4, difficulty=0010, normal, ext_points=0:
  - start → light_en rises 16 cycles after WAIT entry.
  - light_idx = rand_num[3:0] mod 9; rand_num=16'h000C gives light_idx=3.
- Light on at idx 3:
  - key_valid with key_code=3 on ON cycle 5 → hit_count=1, light_en low the next cycle.
  - key_code=7 instead → miss_count=1.
- Light on with no press → miss_count increments after exactly 16 ON cycles.
  - Key pressed in the same cycle as timeout with the correct code → counts as a hit.
- Deathmatch, first round timed out → game_over=1, win=0, busy=0, round_count=1.
- Continuity, LEVEL_STEP=2, all hits → level goes 1→2 after 2 hits and reaches 4 after 6 hits.
  - L4 between-delay = 4 cycles, on-time = 8 cycles.
- Timed, TIMED_UNITS=20, T_UNIT=4 → game_over 80 cycles after start.
- resetn pulsed mid-ON → all outputs 0 and level=1 asynchronously.
- start during a game → ignored.

Source files
------------

// File: rtl/wam_pkg.sv
// rtl/wam_pkg.sv - shared encodings, level timing table and helpers for the whack-a-mole sequencer
`timescale 1ns/1ps
package wam_pkg;

  localparam int PH_W   = 28;
  localparam int GAME_W = 32;  // 60 s at 50 MHz does not fit the 28-bit phase timer
  localparam int CNT_W  = 6;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WAIT  = 3'd1;
  localparam state_t S_ON    = 3'd2;
  localparam state_t S_SCORE = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  localparam logic [3:0] MODE_NORMAL = 4'b0001;
  localparam logic [3:0] MODE_TIMED  = 4'b0010;
  localparam logic [3:0] MODE_DEATH  = 4'b0100;
  localparam logic [3:0] MODE_CONT   = 4'b1000;

  localparam logic [3:0] DIFF_L1 = 4'b0001;
  localparam logic [3:0] DIFF_L2 = 4'b0010;
  localparam logic [3:0] DIFF_L3 = 4'b0100;
  localparam logic [3:0] DIFF_L4 = 4'b1000;

  function automatic logic [2:0] decode_level(input logic [3:0] d);
    case (d)
      DIFF_L1: return 3'd1;
      DIFF_L2: return 3'd2;
      DIFF_L3: return 3'd3;
      DIFF_L4: return 3'd4;
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [3:0] decode_mode(input logic [3:0] m);
    case (m)
      MODE_NORMAL, MODE_TIMED, MODE_DEATH, MODE_CONT: return m;
      default: return MODE_NORMAL;
    endcase
  endfunction

  function automatic int between_units(input logic [2:0] lv);
    case (lv)
      3'd1:    return 8;
      3'd2:    return 4;
      3'd3:    return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int on_units(input logic [2:0] lv);
    case (lv)
      3'd1:    return 8;
      3'd2:    return 4;
      3'd3:    return 4;
      default: return 2;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/wam_game_sequencer_if.sv
// rtl/wam_game_sequencer_if.sv - keypad strobe in, light select out
`timescale 1ns/1ps
interface wam_game_sequencer_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       light_en;
  logic [3:0] light_idx;

  modport master (input key_valid, key_code, output light_en, light_idx);
  modport slave  (output key_valid, key_code, input light_en, light_idx);
endinterface

// File: rtl/wam_countdown.sv
// rtl/wam_countdown.sv - loadable down-counter that stops at zero and flags it
`timescale 1ns/1ps
module wam_countdown #(
  parameter int W = 28
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/wam_game_sequencer.sv
// rtl/wam_game_sequencer.sv - game controller: between-delay, light-on, hit check, scoring
`timescale 1ns/1ps
module wam_game_sequencer
  import wam_pkg::*;
#(
  parameter int T_UNIT      = 12_500_000,
  parameter int TIMED_UNITS = 240,
  parameter int LEVEL_STEP  = 5,
  parameter int NORMAL_PTS  = 25,
  parameter int EXT_PTS     = 50
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [3:0]           difficulty,
  input  logic [3:0]           gamemode,
  input  logic                 ext_points,
  input  logic [15:0]          rand_num,
  wam_game_sequencer_if.master kp,
  output logic [5:0]           hit_count,
  output logic [5:0]           miss_count,
  output logic [5:0]           round_count,
  output logic [2:0]           level,
  output logic                 busy,
  output logic                 game_over,
  output logic                 win
);

  localparam logic [GAME_W-1:0] GAME_LOAD =
    GAME_W'(longint'(TIMED_UNITS) * longint'(T_UNIT) - 64'sd1);

  function automatic logic [PH_W-1:0] units_to_cycles(input int units);
    return PH_W'(units * T_UNIT - 1);
  endfunction

  state_t           state, state_n;
  logic [3:0]       mode;
  logic [CNT_W-1:0] target, hit_step;
  logic [CNT_W-1:0] hits_n, misses_n, rounds_n, step_n;
  logic [2:0]       level_n, start_level;
  logic             hit_flag, end_game, win_n;
  logic [3:0]       light_idx_r, rand_idx;
  logic             ph_load, ph_en, ph_zero, gm_load, gm_en, gm_zero, expire;
  logic [PH_W-1:0]  ph_val;
  logic             unused_rand;

  assign unused_rand = ^rand_num[15:4];
  assign rand_idx    = (rand_num[3:0] < 4'd9) ? rand_num[3:0] : rand_num[3:0] - 4'd9;
  assign start_level = (decode_mode(gamemode) == MODE_CONT) ? 3'd1 : decode_level(difficulty);

  assign busy          = (state == S_WAIT) || (state == S_ON) || (state == S_SCORE);
  assign game_over     = (state == S_DONE);
  assign kp.light_en   = (state == S_ON);
  assign kp.light_idx  = light_idx_r;
  assign ph_en         = (state == S_WAIT) || (state == S_ON);
  assign gm_en         = busy && (mode == MODE_TIMED);
  assign expire        = gm_en && gm_zero;

  wam_countdown #(.W(PH_W)) u_phase (
    .clk      (CLOCK_50),
    .resetn   (resetn),
    .load     (ph_load),
    .en       (ph_en),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  wam_countdown #(.W(GAME_W)) u_game (
    .clk      (CLOCK_50),
    .resetn   (resetn),
    .load     (gm_load),
    .en       (gm_en),
    .load_val (GAME_LOAD),
    .zero     (gm_zero)
  );

  // Score and end-of-game evaluation use the post-increment values of this round.
  always_comb begin
    hits_n   = hit_flag ? sat_inc(hit_count) : hit_count;
    misses_n = hit_flag ? miss_count : sat_inc(miss_count);
    rounds_n = sat_inc(round_count);
    level_n  = level;
    step_n   = hit_step;
    if (mode == MODE_CONT && hit_flag) begin
      if (hit_step == CNT_W'(LEVEL_STEP - 1)) begin
        step_n = '0;
        if (level != 3'd4) level_n = level + 3'd1;
      end else begin
        step_n = hit_step + 1'b1;
      end
    end
    end_game = 1'b0;
    win_n    = 1'b0;
    case (mode)
      MODE_DEATH: begin
        end_game = !hit_flag || (rounds_n == target);
        win_n    = hit_flag;
      end
      MODE_TIMED: end_game = 1'b0;
      default: begin
        end_game = (rounds_n == target);
        win_n    = (hits_n >= misses_n);
      end
    endcase
  end

  always_comb begin
    state_n = state;
    ph_load = 1'b0;
    ph_val  = '0;
    gm_load = 1'b0;
    case (state)
      S_IDLE, S_DONE: if (start) begin
        state_n = S_WAIT;
        ph_load = 1'b1;
        ph_val  = units_to_cycles(between_units(start_level));
        gm_load = 1'b1;
      end
      S_WAIT: if (ph_zero) begin
        state_n = S_ON;
        ph_load = 1'b1;
        ph_val  = units_to_cycles(on_units(level));
      end
      S_ON: if (kp.key_valid || ph_zero) state_n = S_SCORE;
      S_SCORE: begin
        if (end_game) begin
          state_n = S_DONE;
        end else begin
          state_n = S_WAIT;
          ph_load = 1'b1;
          ph_val  = units_to_cycles(between_units(level_n));
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Timed-game expiry abandons whatever round is in flight.
    if (expire) begin
      state_n = S_DONE;
      ph_load = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      mode        <= MODE_NORMAL;
      target      <= '0;
      level       <= 3'd1;
      hit_step    <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      round_count <= '0;
      hit_flag    <= 1'b0;
      light_idx_r <= '0;
      win         <= 1'b0;
    end else begin
      state <= state_n;
      if (expire) begin
        win <= (hit_count >= CNT_W'(NORMAL_PTS));
      end else begin
        case (state)
          S_IDLE, S_DONE: if (start) begin
            mode        <= decode_mode(gamemode);
            target      <= ext_points ? CNT_W'(EXT_PTS) : CNT_W'(NORMAL_PTS);
            level       <= start_level;
            hit_step    <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            round_count <= '0;
            win         <= 1'b0;
          end
          S_WAIT: if (ph_zero) light_idx_r <= rand_idx;
          S_ON: begin
            if (kp.key_valid)  hit_flag <= (kp.key_code == light_idx_r);
            else if (ph_zero)  hit_flag <= 1'b0;
          end
          S_SCORE: begin
            hit_count   <= hits_n;
            miss_count  <= misses_n;
            round_count <= rounds_n;
            level       <= level_n;
            hit_step    <= step_n;
            if (end_game) win <= win_n;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wam_game_sequencer.sv
// tb/tb_wam_game_sequencer.sv - directed self-checking bench for wam_game_sequencer
`timescale 1ns/1ps
module tb_wam_game_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  difficulty = 4'b0010;
  logic [3:0]  gamemode = 4'b0001;
  logic        ext_points = 1'b0;
  logic [15:0] rand_num = 16'h000C;
  logic [5:0]  hit_count, miss_count, round_count;
  logic [2:0]  level;
  logic        busy, game_over, win;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  wam_game_sequencer_if kp();

  wam_game_sequencer #(
    .T_UNIT(4), .TIMED_UNITS(20), .LEVEL_STEP(2), .NORMAL_PTS(25), .EXT_PTS(50)
  ) dut (
    .CLOCK_50    (clk),
    .resetn      (resetn),
    .start       (start),
    .difficulty  (difficulty),
    .gamemode    (gamemode),
    .ext_points  (ext_points),
    .rand_num    (rand_num),
    .kp          (kp),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .round_count (round_count),
    .level       (level),
    .busy        (busy),
    .game_over   (game_over),
    .win         (win)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    kp.key_valid = 1'b0;
    kp.key_code  = 4'd0;
    start        = 1'b0;
    resetn       = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic start_game(input logic [3:0] d, input logic [3:0] m);
    @(negedge clk);
    difficulty = d;
    gamemode   = m;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_light(output int cyc);
    cyc = 0;
    while (kp.light_en !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic press(input logic [3:0] code);
    kp.key_valid = 1'b1;
    kp.key_code  = code;
    @(negedge clk);
    kp.key_valid = 1'b0;
  endtask

  task automatic count_on(output int on);
    on = 0;
    while (kp.light_en === 1'b1 && on < 100) begin
      on++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (kp.light_en !== 1'b0) $display("FAIL reset_light_en got %b want 0", kp.light_en); else pass_cnt++;
    total_cnt++; if (kp.light_idx !== 4'd0) $display("FAIL reset_light_idx got %0d want 0", kp.light_idx); else pass_cnt++;
    total_cnt++; if (hit_count !== 6'd0) $display("FAIL reset_hit got %0d want 0", hit_count); else pass_cnt++;
    total_cnt++; if (miss_count !== 6'd0) $display("FAIL reset_miss got %0d want 0", miss_count); else pass_cnt++;
    total_cnt++; if (round_count !== 6'd0) $display("FAIL reset_round got %0d want 0", round_count); else pass_cnt++;
    total_cnt++; if (level !== 3'd1) $display("FAIL reset_level got %0d want 1", level); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (game_over !== 1'b0) $display("FAIL reset_game_over got %b want 0", game_over); else pass_cnt++;
    total_cnt++; if (win !== 1'b0) $display("FAIL reset_win got %b want 0", win); else pass_cnt++;
  endtask

  task automatic test_light_timing();
    int c;
    do_reset();
    rand_num = 16'h000C;
    start_game(4'b0010, 4'b0001);
    total_cnt++; if (busy !== 1'b1) $display("FAIL start_busy got %b want 1", busy); else pass_cnt++;
    total_cnt++; if (level !== 3'd2) $display("FAIL start_level got %0d want 2", level); else pass_cnt++;
    wait_light(c);
    total_cnt++; if (c != 16) $display("FAIL l2_between got %0d want 16", c); else pass_cnt++;
    total_cnt++; if (kp.light_idx !== 4'd3) $display("FAIL idx_000c got %0d want 3", kp.light_idx); else pass_cnt++;
  endtask

  task automatic test_hit();
    repeat (4) @(negedge clk);
    total_cnt++; if (kp.light_en !== 1'b1) $display("FAIL on_cycle5_lit got %b want 1", kp.light_en); else pass_cnt++;
    press(4'd3);
    total_cnt++; if (kp.light_en !== 1'b0) $display("FAIL hit_light_drop got %b want 0", kp.light_en); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (hit_count !== 6'd1) $display("FAIL hit_count got %0d want 1", hit_count); else pass_cnt++;
    total_cnt++; if (miss_count !== 6'd0) $display("FAIL hit_miss got %0d want 0", miss_count); else pass_cnt++;
    total_cnt++; if (round_count !== 6'd1) $display("FAIL hit_round got %0d want 1", round_count); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int c;
    rand_num = 16'h0005;
    wait_light(c);
    total_cnt++; if (c != 16) $display("FAIL b2b_between got %0d want 16", c); else pass_cnt++;
    total_cnt++; if (kp.light_idx !== 4'd5) $display("FAIL idx_0005 got %0d want 5", kp.light_idx); else pass_cnt++;
    press(4'd7);
    @(negedge clk);
    total_cnt++; if (miss_count !== 6'd1) $display("FAIL wrong_key_miss got %0d want 1", miss_count); else pass_cnt++;
    total_cnt++; if (hit_count !== 6'd1) $display("FAIL wrong_key_hit got %0d want 1", hit_count); else pass_cnt++;
    total_cnt++; if (round_count !== 6'd2) $display("FAIL wrong_key_round got %0d want 2", round_count); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int c, on;
    rand_num = 16'hFFF8;
    wait_light(c);
    total_cnt++; if (kp.light_idx !== 4'd8) $display("FAIL idx_fff8 got %0d want 8", kp.light_idx); else pass_cnt++;
    count_on(on);
    total_cnt++; if (on != 16) $display("FAIL l2_on_time got %0d want 16", on); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (miss_count !== 6'd2) $display("FAIL timeout_miss got %0d want 2", miss_count); else pass_cnt++;
    total_cnt++; if (round_count !== 6'd3) $display("FAIL timeout_round got %0d want 3", round_count); else pass_cnt++;
  endtask

  task automatic test_key_at_timeout();
    int c;
    rand_num = 16'h000C;
    wait_light(c);
    repeat (15) @(negedge clk);
    total_cnt++; if (kp.light_en !== 1'b1) $display("FAIL last_on_cycle_lit got %b want 1", kp.light_en); else pass_cnt++;
    press(4'd3);
    total_cnt++; if (kp.light_en !== 1'b0) $display("FAIL tie_light_drop got %b want 0", kp.light_en); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (hit_count !== 6'd2) $display("FAIL tie_hit got %0d want 2", hit_count); else pass_cnt++;
    total_cnt++; if (miss_count !== 6'd2) $display("FAIL tie_miss got %0d want 2", miss_count); else pass_cnt++;
  endtask

  task automatic test_deathmatch();
    int c, n;
    do_reset();
    start_game(4'b0001, 4'b0100);
    wait_light(c);
    total_cnt++; if (c != 32) $display("FAIL l1_between got %0d want 32", c); else pass_cnt++;
    n = 0;
    while (game_over !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total_cnt++; if (n != 33) $display("FAIL dm_end_cycles got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (win !== 1'b0) $display("FAIL dm_win got %b want 0", win); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL dm_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (round_count !== 6'd1) $display("FAIL dm_round got %0d want 1", round_count); else pass_cnt++;
    total_cnt++; if (miss_count !== 6'd1) $display("FAIL dm_miss got %0d want 1", miss_count); else pass_cnt++;
  endtask

  task automatic test_continuity();
    int c, on;
    int bt [6] = '{32, 32, 16, 16, 8, 8};
    int lv [6] = '{1, 2, 2, 3, 3, 4};
    do_reset();
    rand_num = 16'h000A;
    start_game(4'b1000, 4'b1000);
    total_cnt++; if (level !== 3'd1) $display("FAIL cont_start_level got %0d want 1", level); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      wait_light(c);
      total_cnt++; if (c != bt[i]) $display("FAIL cont_between_%0d got %0d want %0d", i, c, bt[i]); else pass_cnt++;
      press(4'd1);
      @(negedge clk);
      total_cnt++; if (level !== 3'(lv[i])) $display("FAIL cont_level_%0d got %0d want %0d", i, level, lv[i]); else pass_cnt++;
      total_cnt++; if (hit_count !== 6'(i + 1)) $display("FAIL cont_hits_%0d got %0d want %0d", i, hit_count, i + 1); else pass_cnt++;
    end
    wait_light(c);
    total_cnt++; if (c != 4) $display("FAIL l4_between got %0d want 4", c); else pass_cnt++;
    count_on(on);
    total_cnt++; if (on != 8) $display("FAIL l4_on_time got %0d want 8", on); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (level !== 3'd4) $display("FAIL cont_level_cap got %0d want 4", level); else pass_cnt++;
    total_cnt++; if (round_count !== 6'd7) $display("FAIL cont_round got %0d want 7", round_count); else pass_cnt++;
  endtask

  task automatic test_timed();
    int n;
    do_reset();
    start_game(4'b0010, 4'b0010);
    n = 0;
    while (game_over !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total_cnt++; if (n != 80) $display("FAIL timed_length got %0d want 80", n); else pass_cnt++;
    total_cnt++; if (win !== 1'b0) $display("FAIL timed_win got %b want 0", win); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL timed_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (round_count !== 6'd2) $display("FAIL timed_round got %0d want 2", round_count); else pass_cnt++;
    total_cnt++; if (kp.light_en !== 1'b0) $display("FAIL timed_light got %b want 0", kp.light_en); else pass_cnt++;
  endtask

  task automatic test_reset_mid_on();
    int c;
    do_reset();
    rand_num = 16'h000C;
    start_game(4'b0100, 4'b0001);
    wait_light(c);
    total_cnt++; if (c != 8) $display("FAIL l3_between got %0d want 8", c); else pass_cnt++;
    press(4'd3);
    @(negedge clk);
    wait_light(c);
    total_cnt++; if (hit_count !== 6'd1 || level !== 3'd3) $display("FAIL pre_reset got hit=%0d level=%0d want hit=1 level=3", hit_count, level); else pass_cnt++;
    resetn = 1'b0;
    #1;
    total_cnt++; if (kp.light_en !== 1'b0) $display("FAIL async_light got %b want 0", kp.light_en); else pass_cnt++;
    total_cnt++; if (hit_count !== 6'd0) $display("FAIL async_hit got %0d want 0", hit_count); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL async_busy got %b want 0", busy); else pass_cnt++;
    total_cnt++; if (level !== 3'd1) $display("FAIL async_level got %0d want 1", level); else pass_cnt++;
    total_cnt++; if (kp.light_idx !== 4'd0) $display("FAIL async_idx got %0d want 0", kp.light_idx); else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_start_ignored();
    int c, on;
    do_reset();
    start_game(4'b0010, 4'b0001);
    repeat (3) @(negedge clk);
    difficulty = 4'b0001;
    gamemode   = 4'b0100;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_light(c);
    total_cnt++; if (c != 12) $display("FAIL ignored_start_timing got %0d want 12", c); else pass_cnt++;
    total_cnt++; if (level !== 3'd2) $display("FAIL ignored_start_level got %0d want 2", level); else pass_cnt++;
    count_on(on);
    @(negedge clk);
    total_cnt++; if (game_over !== 1'b0) $display("FAIL ignored_start_mode got %b want 0", game_over); else pass_cnt++;
    total_cnt++; if (miss_count !== 6'd1) $display("FAIL ignored_start_miss got %0d want 1", miss_count); else pass_cnt++;
  endtask

  initial begin
    kp.key_valid = 1'b0;
    kp.key_code  = 4'd0;
    test_reset();
    test_light_timing();
    test_hit();
    test_back_to_back();
    test_timeout();
    test_key_at_timeout();
    test_deathmatch();
    test_continuity();
    test_timed();
    test_reset_mid_on();
    test_start_ignored();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
